// File: rtl/lbist_session_seq.sv
// Multi-seed LBIST session sequencer: reset / seed-load / shift-capture loop per
// ROM seed, with a MISR-vs-golden compare and a sticky first-failure record.
module lbist_session_seq #(
  parameter int N_MISR     = 64,
  parameter int SEED_AW    = 4,
  parameter int N_SEEDS    = 16,
  parameter int SHIFT_LEN  = 32,
  parameter int N_PATTERNS = 256,
  parameter int RST_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [N_MISR-1:0]  misr_sig_i,
  input  logic [N_MISR-1:0]  golden_i,
  output logic [SEED_AW-1:0] seed_addr_o,
  output logic               lfsr_ld_o,
  output logic               lfsr_en_o,
  output logic               misr_en_o,
  output logic               scan_en_o,
  output logic               dut_reset_o,
  output logic               lfsr_misr_reset_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [SEED_AW-1:0] fail_seed_o,
  output logic               aborted_o
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int SW = $clog2(SHIFT_LEN) + 1;
  localparam int PW = $clog2(N_PATTERNS) + 1;

  localparam logic [RW-1:0]      RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]      SH_LAST   = SW'(SHIFT_LEN - 1);
  localparam logic [PW-1:0]      PAT_LAST  = PW'(N_PATTERNS - 1);
  localparam logic [SEED_AW-1:0] SEED_LAST = SEED_AW'(N_SEEDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST_SEQ = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]         state, n_state;
  logic [RW-1:0]      rst_cnt, n_rst_cnt;
  logic [SW-1:0]      sh_cnt, n_sh_cnt;
  logic [PW-1:0]      pat_cnt, n_pat_cnt;
  logic [SEED_AW-1:0] n_seed, n_fail_seed;
  logic               fail_flag, n_fail_flag;
  logic               n_aborted;
  logic               busy_st;

  assign busy_st = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    n_state     = state;
    n_rst_cnt   = rst_cnt;
    n_sh_cnt    = sh_cnt;
    n_pat_cnt   = pat_cnt;
    n_seed      = seed_addr_o;
    n_fail_seed = fail_seed_o;
    n_fail_flag = fail_flag;
    n_aborted   = 1'b0;
    if (busy_st && abort_i) begin
      n_state   = S_IDLE;
      n_aborted = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            n_state     = S_RST_SEQ;
            n_rst_cnt   = '0;
            n_seed      = '0;
            n_fail_flag = 1'b0;
            n_fail_seed = '0;
          end
        end
        S_RST_SEQ: begin
          if (rst_cnt == RST_LAST) n_state = S_LOAD;
          else                     n_rst_cnt = rst_cnt + RW'(1);
        end
        S_LOAD: begin
          n_state   = S_SHIFT;
          n_sh_cnt  = '0;
          n_pat_cnt = '0;
        end
        S_SHIFT: begin
          if (sh_cnt == SH_LAST) n_state = S_CAPTURE;
          else                   n_sh_cnt = sh_cnt + SW'(1);
        end
        S_CAPTURE: begin
          n_pat_cnt = pat_cnt + PW'(1);
          n_sh_cnt  = '0;
          n_state   = (pat_cnt == PAT_LAST) ? S_COMPARE : S_SHIFT;
        end
        S_COMPARE: begin
          if ((misr_sig_i != golden_i) && !fail_flag) begin
            n_fail_flag = 1'b1;
            n_fail_seed = seed_addr_o;
          end
          if (seed_addr_o == SEED_LAST) begin
            n_state = S_DONE;
          end else begin
            n_seed    = seed_addr_o + SEED_AW'(1);
            n_rst_cnt = '0;
            n_state   = S_RST_SEQ;
          end
        end
        default: n_state = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      rst_cnt           <= '0;
      sh_cnt            <= '0;
      pat_cnt           <= '0;
      seed_addr_o       <= '0;
      fail_seed_o       <= '0;
      fail_flag         <= 1'b0;
      aborted_o         <= 1'b0;
      lfsr_ld_o         <= 1'b0;
      lfsr_en_o         <= 1'b0;
      misr_en_o         <= 1'b0;
      scan_en_o         <= 1'b0;
      dut_reset_o       <= 1'b1;
      lfsr_misr_reset_o <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
    end else begin
      state             <= n_state;
      rst_cnt           <= n_rst_cnt;
      sh_cnt            <= n_sh_cnt;
      pat_cnt           <= n_pat_cnt;
      seed_addr_o       <= n_seed;
      fail_seed_o       <= n_fail_seed;
      fail_flag         <= n_fail_flag;
      aborted_o         <= n_aborted;
      lfsr_ld_o         <= (n_state == S_LOAD);
      lfsr_en_o         <= (n_state == S_SHIFT) || (n_state == S_CAPTURE);
      misr_en_o         <= (n_state == S_SHIFT);
      scan_en_o         <= (n_state == S_SHIFT);
      dut_reset_o       <= (n_state != S_RST_SEQ);
      lfsr_misr_reset_o <= (n_state == S_RST_SEQ);
      busy_o            <= (n_state != S_IDLE) && (n_state != S_DONE);
      done_o            <= (n_state == S_DONE);
      pass_o            <= (n_state == S_DONE) && !n_fail_flag;
    end
  end

endmodule

// File: tb/tb_lbist_session_seq.sv
// Directed bench for lbist_session_seq with a small session geometry
// (2 reset cycles, 4 shifts, 3 patterns, 2 seeds -> 19 cycles per seed).
module tb_lbist_session_seq;

  localparam int N_MISR  = 64;
  localparam int SEED_AW = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic [N_MISR-1:0]  misr_sig_i, golden_i;
  logic [SEED_AW-1:0] seed_addr_o, fail_seed_o;
  logic lfsr_ld_o, lfsr_en_o, misr_en_o, scan_en_o, dut_reset_o, lfsr_misr_reset_o;
  logic busy_o, done_o, pass_o, aborted_o;

  logic [15:0] bad_mask = '0;
  int errors = 0;
  int checks = 0;

  lbist_session_seq #(
    .N_MISR(N_MISR), .SEED_AW(SEED_AW), .N_SEEDS(2),
    .SHIFT_LEN(4), .N_PATTERNS(3), .RST_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .misr_sig_i(misr_sig_i), .golden_i(golden_i), .seed_addr_o(seed_addr_o),
    .lfsr_ld_o(lfsr_ld_o), .lfsr_en_o(lfsr_en_o), .misr_en_o(misr_en_o),
    .scan_en_o(scan_en_o), .dut_reset_o(dut_reset_o),
    .lfsr_misr_reset_o(lfsr_misr_reset_o), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .fail_seed_o(fail_seed_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  // Golden ROM model: golden differs from the signature for seeds flagged in bad_mask.
  always_comb begin
    misr_sig_i = 64'hA5A5_0000_1234_0000 + 64'(seed_addr_o);
    golden_i   = misr_sig_i ^ {63'b0, bad_mask[seed_addr_o]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input logic [15:0] mask, input logic exp_pass,
                             input logic [3:0] exp_fseed, input bit poke_start);
    int busy_cnt, runs, bad_runs, run_len, ld_cnt, rstlow_cnt, cyc;
    logic [3:0] ld_seed [2];
    bad_mask = mask;
    busy_cnt = 0; runs = 0; bad_runs = 0; run_len = 0; ld_cnt = 0; rstlow_cnt = 0; cyc = 0;
    ld_seed[0] = 4'hF; ld_seed[1] = 4'hF;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (!done_o && cyc < 500) begin
      if (busy_o) busy_cnt++;
      if (!dut_reset_o) rstlow_cnt++;
      if (lfsr_ld_o) begin
        if (ld_cnt < 2) ld_seed[ld_cnt] = seed_addr_o;
        ld_cnt++;
      end
      if (scan_en_o) run_len++;
      else if (run_len != 0) begin
        runs++;
        if (run_len != 4) bad_runs++;
        run_len = 0;
      end
      start_i = poke_start && scan_en_o && (runs == 1);
      tick();
      start_i = 1'b0;
      cyc++;
    end
    check("session_timeout", 64'(cyc < 500), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd38);
    check("done", 64'(done_o), 64'd1);
    check("busy_at_done", 64'(busy_o), 64'd0);
    check("pass", 64'(pass_o), 64'(exp_pass));
    if (!exp_pass) check("fail_seed", 64'(fail_seed_o), 64'(exp_fseed));
    check("scan_runs", 64'(runs), 64'd6);
    check("scan_run_len_bad", 64'(bad_runs), 64'd0);
    check("lfsr_ld_count", 64'(ld_cnt), 64'd2);
    check("seed_seq0", 64'(ld_seed[0]), 64'd0);
    check("seed_seq1", 64'(ld_seed[1]), 64'd1);
    check("dut_reset_low_cycles", 64'(rstlow_cnt), 64'd4);
  endtask

  initial begin
    int cyc;
    int sh;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_pass", 64'(pass_o), 64'd0);
    check("rst_dut_reset", 64'(dut_reset_o), 64'd1);
    check("rst_enables", 64'({lfsr_ld_o, lfsr_en_o, misr_en_o, scan_en_o, lfsr_misr_reset_o}), 64'd0);
    check("rst_seed", 64'(seed_addr_o), 64'd0);
    check("rst_fail_seed", 64'(fail_seed_o), 64'd0);

    // abort in IDLE: ignored
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("idle_abort_pulse", 64'(aborted_o), 64'd0);

    run_session(16'h0000, 1'b1, 4'd0, 1'b0);
    tick();
    check("done_held", 64'({done_o, pass_o}), 64'b11);
    run_session(16'h0002, 1'b0, 4'd1, 1'b0);
    run_session(16'h0003, 1'b0, 4'd0, 1'b0);
    run_session(16'h0000, 1'b1, 4'd0, 1'b1);

    // abort in the 3rd SHIFT cycle of seed 0
    bad_mask = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sh = 0; cyc = 0;
    while (sh < 3 && cyc < 50) begin
      if (scan_en_o) sh++;
      if (sh < 3) begin
        tick();
        cyc++;
      end
    end
    check("abort_reach_shift", 64'(sh), 64'd3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_pulse", 64'(aborted_o), 64'd1);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_dut_reset", 64'(dut_reset_o), 64'd1);
    check("abort_enables", 64'({lfsr_en_o, misr_en_o, scan_en_o, lfsr_misr_reset_o}), 64'd0);
    tick();
    check("abort_pulse_end", 64'(aborted_o), 64'd0);
    run_session(16'h0000, 1'b1, 4'd0, 1'b0);

    // async reset during CAPTURE
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (!(lfsr_en_o && !scan_en_o) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("reach_capture", 64'(lfsr_en_o && !scan_en_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy_o), 64'd0);
    check("async_rst_dut_reset", 64'(dut_reset_o), 64'd1);
    check("async_rst_enables", 64'({lfsr_en_o, misr_en_o, scan_en_o}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_done", 64'(done_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbist_session_seq.md
Name: lbist_session_seq

Overview:
- Multi-seed LBIST session sequencer for the RI5CY core wrapper.
- Drives the LFSR (seed load/enable), scan-enable, MISR enable and DUT/LFSR-MISR resets through one BIST session per ROM seed, using a shift/capture pattern loop.
- At the end of each seed session it compares the MISR signature against a per-seed golden value.
- Reports overall pass/fail and the first failing seed index.

Parameters:
- N_MISR, 64, MISR/signature width
- SEED_AW, 4, seed ROM address width
- N_SEEDS, 16, seeds per session (1..2^SEED_AW)
- SHIFT_LEN, 32, shift cycles per pattern (>=1)
- N_PATTERNS, 256, patterns per seed (>=1)
- RST_CYCLES, 4, DUT/LFSR-MISR reset cycles before each seed (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  start session; sampled in IDLE or DONE
- abort_i  in  1  abort session; sampled in any busy state
- misr_sig_i  in  N_MISR  current MISR signature
- golden_i  in  N_MISR  golden signature for seed_addr_o (combinational ROM)
- seed_addr_o  out  SEED_AW  seed ROM / golden ROM address
- lfsr_ld_o  out  1  LFSR parallel load
- lfsr_en_o  out  1  LFSR advance + TPG mux select
- misr_en_o  out  1  MISR compaction enable
- scan_en_o  out  1  scan shift enable (0 = capture/functional)
- dut_reset_o  out  1  DUT reset release, active-low (0 = DUT held in reset)
- lfsr_misr_reset_o  out  1  LFSR/MISR reset, active-high
- busy_o  out  1  session in progress
- done_o  out  1  session complete, held
- pass_o  out  1  all seeds matched; valid while done_o=1
- fail_seed_o  out  SEED_AW  first failing seed index; valid while done_o=1 and pass_o=0
- aborted_o  out  1  one-cycle pulse on abort

Behaviour:
- Reset values: all outputs 0 except dut_reset_o=1; seed_addr_o=0; state IDLE. Async rst overrides any state immediately.
- All outputs are registered. Control outputs are a decode of the current state.
- IDLE: all enables 0. start_i=1 goes to RST_SEQ next cycle, sets busy_o, and clears pass/fail/seed counter.
- RST_SEQ: dut_reset_o=0 and lfsr_misr_reset_o=1 for exactly RST_CYCLES cycles, then LOAD.
- LOAD: 1 cycle. lfsr_ld_o=1, dut_reset_o=1. Then SHIFT with pattern counter=0.
- SHIFT: SHIFT_LEN cycles. scan_en_o=1, lfsr_en_o=1, misr_en_o=1. Then CAPTURE.
- CAPTURE: 1 cycle. scan_en_o=0, lfsr_en_o=1, misr_en_o=0. Pattern counter increments. If counter reaches N_PATTERNS go to COMPARE, else go to SHIFT.
- COMPARE: 1 cycle. If misr_sig_i != golden_i and no earlier failure, latch fail_seed_o=seed_addr_o and set the sticky fail flag.
  - If seed_addr_o == N_SEEDS-1 go to DONE.
  - Otherwise seed_addr_o increments and the FSM goes to RST_SEQ.
- DONE: busy_o=0, done_o=1, pass_o=~fail. Held until start_i=1, which restarts as from IDLE.
- Cycles per seed = RST_CYCLES + 1 + N_PATTERNS*(SHIFT_LEN+1) + 1.
- Counters are sized clog2(param)+1 and must not wrap during a valid session. seed_addr_o never exceeds N_SEEDS-1.
- abort_i=1 in any busy state: next cycle goes to IDLE, all enables 0, dut_reset_o=1, busy_o=0, aborted_o=1 for one cycle, done_o stays 0.
  - abort_i has priority over start_i and over every state transition.
- start_i while busy: ignored.
- abort_i in IDLE or DONE: ignored, no pulse.
- rst mid-session: immediate return to reset values; pass/fail are lost.

Test Plan:
- Reset, then idle 10 cycles -> all outputs at reset values; dut_reset_o=1, busy_o=0.
- Params RST_CYCLES=2, SHIFT_LEN=4, N_PATTERNS=3, N_SEEDS=2; start pulse with golden_i==misr_sig_i -> busy_o=1 for 38 cycles, done_o=1, pass_o=1. Also check:
  - scan_en_o high-run lengths: 4,4,4 per seed
  - lfsr_ld_o asserted twice
  - seed_addr_o sequence 0→1
- Same params, mismatch only when seed_addr_o=1 -> done_o=1, pass_o=0, fail_seed_o=1.
- Mismatch on both seeds -> fail_seed_o=0 (first failure kept).
- abort_i pulsed during the 3rd SHIFT cycle of seed 0 -> next cycle IDLE, aborted_o 1-cycle pulse, done_o=0. A following start_i runs a full 38-cycle session.
- Async rst asserted mid-CAPTURE, and start_i asserted while in SHIFT -> rst: outputs reset immediately, no clock edge required; start_i: no effect on the cycle count.
